// File: rtl/simon_iter_core.sv
// Iterative Simon block cipher engine: one round per clock. The key window is updated
// on the fly (forward for encrypt, reverse for decrypt), so both modes share one round datapath.
module simon_iter_core #(
    parameter int          N     = 16,
    parameter int          M     = 4,
    parameter int          T     = 32,
    parameter logic [61:0] Z_SEQ = 62'h3E8958737D12B0E6
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           in_decrypt,
    input  logic [N-1:0]   in_low,
    input  logic [N-1:0]   in_high,
    input  logic [N*M-1:0] in_key,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   out_low,
    output logic [N-1:0]   out_high
);
    localparam int            CW       = $clog2(T + 1);
    localparam logic [CW-1:0] LAST_RND = CW'(T - 1);
    localparam logic [CW-1:0] LAST_FWD = CW'(T - M - 1);
    localparam logic [N-1:0]  RC       = N'(3);

    typedef enum logic [1:0] {IDLE, KEYFWD, ROUND, DONE} state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt;
    logic [5:0]     zidx, zidx_inc, zidx_dec;
    logic           dec;
    logic [N-1:0]   l_r, h_r, l_nxt, rk;
    logic [N-1:0]   kw [M];
    logic [N-1:0]   t_fwd0, t_rev0, t_fwd, t_rev, k_fwd, k_rev;
    logic [N-1:0]   z_fwd, z_rev;
    logic           accept, cnt_last;

    function automatic logic [N-1:0] rol(input logic [N-1:0] x, input int s);
        return (x << s) | (x >> (N - s));
    endfunction

    function automatic logic [N-1:0] ror(input logic [N-1:0] x, input int s);
        return rol(x, N - s);
    endfunction

    function automatic logic [N-1:0] simon_f(input logic [N-1:0] x);
        return (rol(x, 1) & rol(x, 8)) ^ rol(x, 2);
    endfunction

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_ready && in_valid;
    assign cnt_last  = (state == KEYFWD) ? (cnt == LAST_FWD) : (cnt == LAST_RND);

    // z index walks the 62-entry sequence in either direction, wrapping explicitly at 61/0
    assign zidx_inc = (zidx == 6'd61) ? 6'd0  : zidx + 6'd1;
    assign zidx_dec = (zidx == 6'd0)  ? 6'd61 : zidx - 6'd1;
    assign z_fwd    = {{(N-1){1'b0}}, Z_SEQ[6'd61 - zidx]};
    assign z_rev    = {{(N-1){1'b0}}, Z_SEQ[6'd61 - zidx_dec]};

    generate
        if (M == 4) begin : g_m4
            assign t_fwd0 = ror(kw[M-1], 3) ^ kw[1];
            assign t_rev0 = ror(kw[M-2], 3) ^ kw[0];
        end else begin : g_m23
            assign t_fwd0 = ror(kw[M-1], 3);
            assign t_rev0 = ror(kw[M-2], 3);
        end
    endgenerate

    assign t_fwd = t_fwd0 ^ ror(t_fwd0, 1);
    assign t_rev = t_rev0 ^ ror(t_rev0, 1);
    assign k_fwd = ~kw[0] ^ t_fwd ^ z_fwd ^ RC;
    assign k_rev = ~(kw[M-1] ^ t_rev ^ z_rev ^ RC);

    // Decrypt runs the same round on swapped words, consuming keys from the window top
    assign rk    = dec ? kw[M-1] : kw[0];
    assign l_nxt = h_r ^ simon_f(l_r) ^ rk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = in_decrypt ? KEYFWD : ROUND;
            KEYFWD:  if (cnt_last) state_nxt = ROUND;
            ROUND:   if (cnt_last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            zidx     <= '0;
            dec      <= 1'b0;
            out_low  <= '0;
            out_high <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cnt  <= '0;
                        zidx <= '0;
                        dec  <= in_decrypt;
                    end
                end
                KEYFWD: begin
                    cnt  <= cnt_last ? '0 : cnt + 1'b1;
                    zidx <= zidx_inc;
                end
                ROUND: begin
                    cnt  <= cnt_last ? '0 : cnt + 1'b1;
                    zidx <= dec ? zidx_dec : zidx_inc;
                    if (cnt_last) begin
                        out_low  <= dec ? l_r : l_nxt;
                        out_high <= dec ? l_nxt : l_r;
                    end
                end
                default: ;
            endcase
        end
    end

    // Data words and key window carry no reset; they are always reloaded at accept
    always_ff @(posedge clk) begin
        if (accept) begin
            l_r <= in_decrypt ? in_high : in_low;
            h_r <= in_decrypt ? in_low : in_high;
            for (int i = 0; i < M; i++) kw[i] <= in_key[N*i +: N];
        end else if (state == KEYFWD || (state == ROUND && !dec)) begin
            if (state == ROUND) begin
                l_r <= l_nxt;
                h_r <= l_r;
            end
            for (int i = 0; i < M - 1; i++) kw[i] <= kw[i+1];
            kw[M-1] <= k_fwd;
        end else if (state == ROUND) begin
            l_r <= l_nxt;
            h_r <= l_r;
            for (int i = 1; i < M; i++) kw[i] <= kw[i-1];
            kw[0] <= k_rev;
        end
    end

endmodule
